// File: rtl/e_arb_if.sv
// Request/response bundle for e_arb: N valid/ready request channels and one
// valid/ready response channel carrying the requester id and decision.
interface e_arb_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [N-1:0]         i_req_vld;
  logic [N*W-1:0]       i_req_x;
  logic [N-1:0]         o_req_rdy;
  logic                 o_rsp_vld;
  logic [$clog2(N)-1:0] o_rsp_id;
  logic [W-1:0]         o_rsp_x;
  logic                 o_rsp_is_unary;
  logic                 i_rsp_rdy;

  // A transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a presented payload holds until it transfers.
  modport master (
    output i_req_vld, i_req_x, i_rsp_rdy,
    input  o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_x, o_rsp_is_unary
  );

  modport slave (
    input  i_req_vld, i_req_x, i_rsp_rdy,
    output o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_x, o_rsp_is_unary
  );
endinterface

// File: rtl/e_arb.sv
// Round-robin arbiter sharing one unary-admission checker across N requesters.
// Optional E_ARB_REJECT_CNT_EN adds a saturating count of rejected slot loads.
module e_arb #(
  parameter int N                     = 4,
  parameter int W                     = 16,
  parameter int P_ADMIT_COMPLIMENT_EN = 0
) (
  input  logic        clk,
  input  logic        rst,
  e_arb_if.slave      bus
`ifdef E_ARB_REJECT_CNT_EN
  ,
  output logic [15:0] o_reject_cnt
`endif
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic          r_rsp_vld;
  logic [IW-1:0] r_rsp_id;
  logic [W-1:0]  r_rsp_x;
  logic          r_rsp_is_unary;

  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_gnt_idx;
  logic          w_any;
  int            w_k;
  logic [W-1:0]  w_gnt_x;
  logic          w_gnt_unary;
  logic          w_slot_free;
  logic          w_accept;

  // Exactly one edge means a thermometer code of either polarity.
  function automatic logic f_is_unary(input logic [W-1:0] x);
    logic [W-1:0] e;
    logic         flat;
    e        = '0;
    e[W-1:1] = x[W-1:1] ^ x[W-2:0];
    flat     = (P_ADMIT_COMPLIMENT_EN != 0) ? (x == '1) : (x == '0);
    return ($countones(e) == 1) || flat;
  endfunction

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    w_k       = 0;
    for (int j = 0; j < N; j++) begin
      w_k = int'(r_ptr) + j;
      if (w_k >= N) w_k = w_k - N;
      if (!w_any && bus.i_req_vld[w_k]) begin
        w_any        = 1'b1;
        w_grant[w_k] = 1'b1;
        w_gnt_idx    = IW'(w_k);
      end
    end
  end

  assign w_gnt_x     = bus.i_req_x[int'(w_gnt_idx)*W +: W];
  assign w_gnt_unary = f_is_unary(w_gnt_x);
  assign w_slot_free = !r_rsp_vld || bus.i_rsp_rdy;
  assign w_accept    = w_any && w_slot_free && !rst;

  assign bus.o_req_rdy      = (w_slot_free && !rst) ? w_grant : '0;
  assign bus.o_rsp_vld      = r_rsp_vld;
  assign bus.o_rsp_id       = r_rsp_id;
  assign bus.o_rsp_x        = r_rsp_x;
  assign bus.o_rsp_is_unary = r_rsp_is_unary;

  // An accept overwrites the slot even while it drains, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr          <= '0;
      r_rsp_vld      <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_x        <= '0;
      r_rsp_is_unary <= 1'b0;
    end else if (w_accept) begin
      r_rsp_vld      <= 1'b1;
      r_rsp_id       <= w_gnt_idx;
      r_rsp_x        <= w_gnt_x;
      r_rsp_is_unary <= w_gnt_unary;
      r_ptr          <= (w_gnt_idx == IW'(N-1)) ? '0 : w_gnt_idx + IW'(1);
    end else if (r_rsp_vld && bus.i_rsp_rdy) begin
      r_rsp_vld <= 1'b0;
    end
  end

`ifdef E_ARB_REJECT_CNT_EN
  logic [15:0] r_reject_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reject_cnt <= '0;
    end else if (w_accept && !w_gnt_unary && (r_reject_cnt != 16'hFFFF)) begin
      r_reject_cnt <= r_reject_cnt + 16'd1;
    end
  end

  assign o_reject_cnt = r_reject_cnt;
`endif
endmodule

// File: tb/tb_e_arb.sv
// Scoreboard bench for e_arb: one P=0 and one P=1 instance driven in lockstep
// against a round-robin/thermometer reference model.
`timescale 1ns/1ps
module tb_e_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int EW = IW + W + 2;

  logic clk;
  logic rst;

  e_arb_if #(.N(N), .W(W)) bus0 ();
  e_arb_if #(.N(N), .W(W)) bus1 ();

`ifdef E_ARB_REJECT_CNT_EN
  logic [15:0] rej0;
  logic [15:0] rej1;
`endif

  e_arb #(.N(N), .W(W), .P_ADMIT_COMPLIMENT_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef E_ARB_REJECT_CNT_EN
    , .o_reject_cnt(rej0)
`endif
  );

  e_arb #(.N(N), .W(W), .P_ADMIT_COMPLIMENT_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef E_ARB_REJECT_CNT_EN
    , .o_reject_cnt(rej1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  cur_x[N];
  int m_ptr;
  bit m_full;
  int m_rej0;
  int m_rej1;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // thermometer codes of either polarity, plus the flat vector of the admitted polarity
  function automatic logic m_unary(input logic [W-1:0] x, input bit pol);
    logic [W-1:0] t;
    if (x == (pol ? {W{1'b1}} : {W{1'b0}})) return 1'b1;
    for (int s = 1; s < W; s++) begin
      t = (W'(1) << s) - W'(1);
      if (x == t || x == ~t) return 1'b1;
    end
    return 1'b0;
  endfunction

  // driver: one cycle of stimulus, grant check and model update
  task automatic step(input logic [N-1:0] vld, input logic rrdy, input logic rv);
    logic [N-1:0]  g;
    logic [N-1:0]  er;
    logic [EW-1:0] e;
    int            k;
    int            sel;
    bit            found;
    @(negedge clk);
    rst            = rv;
    bus0.i_req_vld = vld;
    bus1.i_req_vld = vld;
    bus0.i_rsp_rdy = rrdy;
    bus1.i_rsp_rdy = rrdy;
    for (int j = 0; j < N; j++) begin
      bus0.i_req_x[j*W +: W] = cur_x[j];
      bus1.i_req_x[j*W +: W] = cur_x[j];
    end
    #2;
`ifdef E_ARB_REJECT_CNT_EN
    chk("reject_cnt_p0", 32'(rej0), m_rej0);
    chk("reject_cnt_p1", 32'(rej1), m_rej1);
`endif
    g     = '0;
    found = 1'b0;
    sel   = 0;
    for (int j = 0; j < N; j++) begin
      k = (m_ptr + j) % N;
      if (!found && vld[k]) begin
        found  = 1'b1;
        g[k]   = 1'b1;
        sel    = k;
      end
    end
    er = (rv || (m_full && !rrdy)) ? '0 : g;
    chk("req_rdy_p0", 32'(bus0.o_req_rdy), 32'(er));
    chk("req_rdy_p1", 32'(bus1.o_req_rdy), 32'(er));
    if (rv) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_rej0 = 0;
      m_rej1 = 0;
      exp_q.delete();
    end else if (er != '0) begin
      e = {IW'(sel), cur_x[sel], m_unary(cur_x[sel], 1'b0), m_unary(cur_x[sel], 1'b1)};
      exp_q.push_back(e);
      m_full = 1'b1;
      m_ptr  = (sel + 1) % N;
      if (!e[1] && m_rej0 < 65535) m_rej0++;
      if (!e[0] && m_rej1 < 65535) m_rej1++;
      cur_x[sel] = W'($urandom_range(0, (1 << W) - 1));
    end else if (rrdy) begin
      m_full = 1'b0;
    end
  endtask

  // monitor: compares the presented response with the queue head, pops on transfer
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("rsp_vld_p0", 32'(bus0.o_rsp_vld), 32'(exp_q.size() != 0));
        chk("rsp_vld_p1", 32'(bus1.o_rsp_vld), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0 && bus0.o_rsp_vld && bus1.o_rsp_vld) begin
          e = exp_q[0];
          chk("rsp_id_p0",  32'(bus0.o_rsp_id),       32'(e[EW-1 -: IW]));
          chk("rsp_x_p0",   32'(bus0.o_rsp_x),        32'(e[W+1:2]));
          chk("unary_p0",   32'(bus0.o_rsp_is_unary), 32'(e[1]));
          chk("rsp_id_p1",  32'(bus1.o_rsp_id),       32'(e[EW-1 -: IW]));
          chk("rsp_x_p1",   32'(bus1.o_rsp_x),        32'(e[W+1:2]));
          chk("unary_p1",   32'(bus1.o_rsp_is_unary), 32'(e[0]));
          if (bus0.i_rsp_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  logic [W-1:0] dec_vals[6];

  initial begin
    rst = 1'b1;
    bus0.i_req_vld = '0; bus1.i_req_vld = '0;
    bus0.i_req_x   = '0; bus1.i_req_x   = '0;
    bus0.i_rsp_rdy = 1'b0; bus1.i_rsp_rdy = 1'b0;
    m_ptr = 0; m_full = 1'b0; m_rej0 = 0; m_rej1 = 0;
    for (int j = 0; j < N; j++) cur_x[j] = W'($urandom_range(0, 255));
    dec_vals[0] = 8'h07; dec_vals[1] = 8'h00; dec_vals[2] = 8'hF0;
    dec_vals[3] = 8'hFF; dec_vals[4] = 8'h50; dec_vals[5] = 8'h01;

    // reset: requests present but nothing granted, slot cleared
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    chk("rst_rsp_vld",   32'(bus0.o_rsp_vld), 0);
    chk("rst_rsp_id",    32'(bus0.o_rsp_id), 0);
    chk("rst_rsp_x",     32'(bus0.o_rsp_x), 0);
    chk("rst_rsp_unary", 32'(bus0.o_rsp_is_unary), 0);
    mon_en = 1'b1;

    // fairness: everyone requesting, consumer always ready
    repeat (12) step(4'hF, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);

    // decision values through requester 0
    for (int i = 0; i < 6; i++) begin
      cur_x[0] = dec_vals[i];
      step(4'b0001, 1'b1, 1'b0);
    end
    step(4'h0, 1'b1, 1'b0);

    // backpressure: slot full and consumer stalled for 3 cycles
    step(4'hF, 1'b1, 1'b0);
    repeat (3) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);

    // pointer wrap: set ptr=2, then 3 and 1 compete
    step(4'b0010, 1'b1, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);

    // random traffic with random consumer stalls
    repeat (400) step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0);

    // reset with a pending response
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0);
    chk("mid_rst_rsp_vld", 32'(bus0.o_rsp_vld), 0);

    // five rejects for the P=0 checker, then reset
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N; j++) cur_x[j] = 8'hFF;
      step(4'hF, 1'b1, 1'b0);
    end
    step(4'h0, 1'b1, 1'b0);
`ifdef E_ARB_REJECT_CNT_EN
    chk("reject_cnt_five", 32'(rej0), 5);
`endif
    step(4'h0, 1'b1, 1'b1);
    step(4'h0, 1'b1, 1'b0);
`ifdef E_ARB_REJECT_CNT_EN
    chk("reject_cnt_cleared", 32'(rej0), 0);
`endif
    step(4'h0, 1'b1, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/e_arb.md
Name: e_arb

Overview:
- Shares one unary-admission checker between N requesters.
- Round-robin arbitration over valid/ready request channels.
- Checks the granted vector and registers the decision into a single response slot, tagged with the requester index.
- Sits in front of consumers of thermometer-coded control vectors, so N clients do not each need their own checker.

Parameters:
- N, 4: number of requesters, N >= 2.
- W, 16: vector bit-width, W >= 2.
- P_ADMIT_COMPLIMENT_EN, 0: polarity of the "no-edge" vector admitted by the checker.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_vld  in  N  per-requester request valid
- i_req_x  in  N*W  per-requester vector; requester k occupies bits [k*W +: W]
- o_req_rdy  out  N  per-requester grant/accept, one-hot or zero
- o_rsp_vld  out  1  response valid
- o_rsp_id  out  $clog2(N)  index of the requester the response belongs to
- o_rsp_x  out  W  echoed vector
- o_rsp_is_unary  out  1  admission decision
- i_rsp_rdy  in  1  response consumer ready

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Admission rule, combinational on the granted vector. Edge vector: e[0]=0, e[i]=x[i]^x[i-1].
  - is_unary = (popcount(e)==1) | (P_ADMIT_COMPLIMENT_EN ? x=='1 : x=='0).
  - Both polarities with exactly one edge are admitted regardless of P_ADMIT_COMPLIMENT_EN.
- Response slot: a single register (vld, id, x, is_unary).
  - slot_free = !o_rsp_vld | i_rsp_rdy.
- Arbitration:
  - Round-robin pointer ptr, range 0..N-1.
  - The grant goes to the first k with i_req_vld[k] set, searching ptr, ptr+1, ... mod N.
  - o_req_rdy[k] = grant[k] & slot_free.
  - o_req_rdy depends combinationally on i_req_vld and i_rsp_rdy; it has no dependency on itself.
- Accept (vld & rdy on requester k):
  - On the next edge the slot loads {1, k, x_k, is_unary(x_k)}.
  - ptr <= (k+1) mod N.
- Drain: o_rsp_vld & i_rsp_rdy with no accept in the same cycle -> o_rsp_vld <= 0.
- Latency and throughput:
  - Request accept to o_rsp_vld is 1 cycle.
  - Full throughput, 1 response/cycle, while i_rsp_rdy=1.
  - Simultaneous drain and accept replaces the slot contents in the same cycle, with no bubble.
- Backpressure: o_rsp_vld=1 & i_rsp_rdy=0 -> all o_req_rdy=0; slot contents held stable.
- No requests valid: ptr unchanged; slot drains normally.
- Requester rules:
  - A requester holds i_req_x stable while valid and not accepted.
  - A requester may deassert valid before accept; the arbiter does not require stickiness.
- Wrap: ptr at N-1 after accepting requester N-1 becomes 0.
- Reset values:
  - o_rsp_vld=0, ptr=0, o_rsp_id=0, o_rsp_x=0, o_rsp_is_unary=0.
  - o_req_rdy=0 during reset.
- Reset mid-operation: a pending response is dropped and the pointer returns to 0. No request is accepted in a reset cycle.
- X-safety: o_rsp_id, o_rsp_x and o_rsp_is_unary are don't-care when o_rsp_vld=0, but they are reset to 0.

Optional Feature:
- Macro: E_ARB_REJECT_CNT_EN.
- With the macro defined:
  - Extra output o_reject_cnt, 16 bits: a saturating count of slot loads with is_unary=0.
  - Reset to 0; sticks at 16'hFFFF on saturation.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Fairness (N=4, W=8, P=0): all four requesters valid continuously, i_rsp_rdy=1 -> o_rsp_id sequence 0,1,2,3,0,... Exactly one o_req_rdy bit set each cycle.
- Decision values (W=8, P=0), one per accepted request:
  - 8'h07 -> 1; 8'h00 -> 1; 8'hF0 -> 1
  - 8'hFF -> 0; 8'h50 -> 0
- Decision values (W=8, P=1): 8'hFF -> 1; 8'h00 -> 0; 8'h01 -> 1.
- Backpressure: slot full and i_rsp_rdy=0 for 3 cycles -> o_req_rdy=0 and o_rsp_* stable. On i_rsp_rdy=1 the next grant loads the same cycle, so o_rsp_vld stays 1.
- Pointer wrap (requesters 3 and 1 valid, ptr=2): grant 3, then grant 1, then ptr=2.
- Reset mid-stream: assert rst with o_rsp_vld=1 -> next cycle o_rsp_vld=0, ptr=0. With E_ARB_REJECT_CNT_EN, five rejects then reset -> o_reject_cnt goes 5 -> 0.
